// File: rtl/uart_rx_frame_parser.sv
// Framed UART command parser: HEADER, CMD, [COUNT], payload items, CRC-8 residue check.
// Drives an N-byte operand core, its pipeline enable and reset, and reports coded errors.
module uart_rx_frame_parser #(
  parameter int unsigned PAYLOAD_BYTES  = 6,
  parameter logic [7:0]  HEADER_BYTE    = 8'h5a,
  parameter int unsigned MAX_BURST      = 255,
  parameter logic [7:0]  CRC_POLY       = 8'h07,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [7:0]                 i_rx_byte,
  input  logic                       i_rx_byte_valid,
  input  logic                       i_rx_err,
  output logic [7:0]                 o_cmd,
  output logic                       o_cmd_valid,
  output logic [7:0]                 o_burst_cnt,
  output logic [8*PAYLOAD_BYTES-1:0] o_payload,
  output logic                       o_payload_valid,
  output logic                       o_msg_done,
  output logic                       o_msg_err,
  output logic [2:0]                 o_err_code,
  output logic                       o_pipeline_en,
  output logic                       o_core_rst_n
);

  localparam int unsigned PW    = 8 * PAYLOAD_BYTES;
  localparam int unsigned IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [7:0] CMD_SINGLE  = 8'hd1;
  localparam logic [7:0] CMD_BURST   = 8'hd2;
  localparam logic [7:0] CMD_DISABLE = 8'he1;
  localparam logic [7:0] CMD_ENABLE  = 8'he2;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_CMD     = 3'd1;
  localparam logic [2:0] ERR_LEN     = 3'd2;
  localparam logic [2:0] ERR_CRC     = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_RX      = 3'd5;

  typedef enum logic [2:0] {
    ST_HEADER,
    ST_CMD,
    ST_LEN,
    ST_PAYLOAD,
    ST_CRC
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        crc_q, crc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        rem_q, rem_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [7:0]        cmd_q, cmd_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [7:0]        burst_q, burst_d;
  logic [PW-1:0]     payload_q, payload_d;
  logic              payload_valid_q, payload_valid_d;
  logic              msg_done_q, msg_done_d;
  logic              msg_err_q, msg_err_d;
  logic [2:0]        err_code_q, err_code_d;
  logic              pen_q, pen_d;
  logic              core_rst_n_q, core_rst_n_d;

  logic              abort;
  logic [2:0]        abort_code;
  logic [7:0]        crc_next;
  logic [TMR_W-1:0]  timer_inc;

  // Whole-byte CRC-8 step, MSB first, so the residue is ready in the same cycle.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= ST_HEADER;
      crc_q           <= '0;
      idx_q           <= '0;
      rem_q           <= '0;
      timer_q         <= '0;
      cmd_q           <= '0;
      cmd_valid_q     <= 1'b0;
      burst_q         <= '0;
      payload_q       <= '0;
      payload_valid_q <= 1'b0;
      msg_done_q      <= 1'b0;
      msg_err_q       <= 1'b0;
      err_code_q      <= ERR_NONE;
      pen_q           <= 1'b1;
      core_rst_n_q    <= 1'b1;
    end else begin
      state_q         <= state_d;
      crc_q           <= crc_d;
      idx_q           <= idx_d;
      rem_q           <= rem_d;
      timer_q         <= timer_d;
      cmd_q           <= cmd_d;
      cmd_valid_q     <= cmd_valid_d;
      burst_q         <= burst_d;
      payload_q       <= payload_d;
      payload_valid_q <= payload_valid_d;
      msg_done_q      <= msg_done_d;
      msg_err_q       <= msg_err_d;
      err_code_q      <= err_code_d;
      pen_q           <= pen_d;
      core_rst_n_q    <= core_rst_n_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    crc_d           = crc_q;
    idx_d           = idx_q;
    rem_d           = rem_q;
    timer_d         = timer_q;
    cmd_d           = cmd_q;
    burst_d         = burst_q;
    payload_d       = payload_q;
    err_code_d      = err_code_q;
    pen_d           = pen_q;
    cmd_valid_d     = 1'b0;
    payload_valid_d = 1'b0;
    msg_done_d      = 1'b0;
    msg_err_d       = 1'b0;
    core_rst_n_d    = 1'b1;
    abort           = 1'b0;
    abort_code      = ERR_NONE;
    crc_next        = crc8_byte(crc_q, i_rx_byte);
    timer_inc       = timer_q + 1'b1;

    if (state_q == ST_HEADER) begin
      crc_d   = '0;
      idx_d   = '0;
      rem_d   = '0;
      timer_d = '0;
    end

    // A receiver error wins over any byte arriving in the same cycle.
    if (i_rx_err) begin
      abort        = 1'b1;
      abort_code   = ERR_RX;
      core_rst_n_d = 1'b0;
    end else if (i_rx_byte_valid) begin
      timer_d = '0;
      case (state_q)
        ST_HEADER: begin
          if (i_rx_byte == HEADER_BYTE) state_d = ST_CMD;
        end
        ST_CMD: begin
          cmd_d       = i_rx_byte;
          cmd_valid_d = 1'b1;
          crc_d       = crc_next;
          case (i_rx_byte)
            CMD_SINGLE: begin
              burst_d = 8'd1;
              rem_d   = 8'd1;
              state_d = ST_PAYLOAD;
            end
            CMD_BURST:               state_d = ST_LEN;
            CMD_DISABLE, CMD_ENABLE: state_d = ST_CRC;
            default: begin
              abort      = 1'b1;
              abort_code = ERR_CMD;
            end
          endcase
        end
        ST_LEN: begin
          crc_d = crc_next;
          if (i_rx_byte == 8'd0 || i_rx_byte > 8'(MAX_BURST)) begin
            abort      = 1'b1;
            abort_code = ERR_LEN;
          end else begin
            burst_d = i_rx_byte;
            rem_d   = i_rx_byte;
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          crc_d = crc_next;
          for (int k = 0; k < PAYLOAD_BYTES; k++) begin
            if (idx_q == IDX_W'(k)) payload_d[8*k +: 8] = i_rx_byte;
          end
          if (idx_q == IDX_W'(PAYLOAD_BYTES - 1)) begin
            idx_d           = '0;
            payload_valid_d = 1'b1;
            rem_d           = rem_q - 8'd1;
            if (rem_q == 8'd1) state_d = ST_CRC;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        ST_CRC: begin
          msg_done_d = 1'b1;
          crc_d      = '0;
          state_d    = ST_HEADER;
          if (crc_next != 8'h00) begin
            msg_err_d  = 1'b1;
            err_code_d = ERR_CRC;
          end else begin
            err_code_d = ERR_NONE;
            if (cmd_q == CMD_DISABLE) begin
              pen_d        = 1'b0;
              core_rst_n_d = 1'b0;
            end else if (cmd_q == CMD_ENABLE) begin
              pen_d = 1'b1;
            end
          end
        end
        default: state_d = ST_HEADER;
      endcase
    end else if (TIMEOUT_CYCLES != 0 && state_q != ST_HEADER) begin
      timer_d = timer_inc;
      if (timer_inc == TMR_W'(TIMEOUT_CYCLES)) begin
        abort      = 1'b1;
        abort_code = ERR_TIMEOUT;
      end
    end

    if (abort) begin
      msg_done_d = 1'b1;
      msg_err_d  = 1'b1;
      err_code_d = abort_code;
      crc_d      = '0;
      idx_d      = '0;
      rem_d      = '0;
      timer_d    = '0;
      state_d    = ST_HEADER;
    end
  end

  assign o_cmd           = cmd_q;
  assign o_cmd_valid     = cmd_valid_q;
  assign o_burst_cnt     = burst_q;
  assign o_payload       = payload_q;
  assign o_payload_valid = payload_valid_q;
  assign o_msg_done      = msg_done_q;
  assign o_msg_err       = msg_err_q;
  assign o_err_code      = err_code_q;
  assign o_pipeline_en   = pen_q;
  assign o_core_rst_n    = core_rst_n_q;

endmodule

// File: doc/uart_rx_frame_parser.md
Name: uart_rx_frame_parser

Overview:
- Parametrised successor to the fixed-format UART command receiver. Parses framed byte streams from uart_rx and drives the CORDIC core (or any N-byte-operand core) and uart_tx_msg.
- Generalised in header value, payload width, maximum burst length, CRC polynomial and inter-byte timeout.
- Adds byte-wise single-cycle CRC-8, CRC-gated enable/disable commit, inter-byte timeout and a coded error report.

Parameters:
- PAYLOAD_BYTES, 6, bytes per operand item (1..16).
- HEADER_BYTE, 8'h5a, frame start byte.
- MAX_BURST, 255, largest legal burst count (1..255).
- CRC_POLY, 8'h07, CRC-8 polynomial (MSB-first, init 8'h00, no reflection, no xorout).
- TIMEOUT_CYCLES, 0, max idle cycles between bytes inside a frame; 0 disables the timeout.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_rx_byte  in  8  received byte
- i_rx_byte_valid  in  1  one-cycle strobe, i_rx_byte valid
- i_rx_err  in  1  framing/parity error strobe from uart_rx
- o_cmd  out  8  accepted command byte
- o_cmd_valid  out  1  one-cycle pulse with o_cmd
- o_burst_cnt  out  8  item count of current frame (1 for single)
- o_payload  out  8*PAYLOAD_BYTES  assembled operand, first byte in bits [7:0]
- o_payload_valid  out  1  one-cycle pulse per completed item
- o_msg_done  out  1  one-cycle pulse at end of every frame (good or bad)
- o_msg_err  out  1  qualifies o_msg_done; also pulses on aborts
- o_err_code  out  3  0 none, 1 bad cmd, 2 bad len, 3 CRC, 4 timeout, 5 rx err; held until next o_msg_done
- o_pipeline_en  out  1  core pipeline enable (level)
- o_core_rst_n  out  1  core reset, one-cycle low pulse

Behaviour:
- Reset values: o_cmd, o_burst_cnt, o_payload, o_err_code = 0; all pulses = 0; o_pipeline_en = 1; o_core_rst_n = 1; state = HEADER; crc = 0; timer = 0.
- Frame format: HEADER, CMD, [COUNT if burst], COUNT*PAYLOAD_BYTES payload bytes, CRC.
- CRC covers CMD through the CRC byte, running from init 0; the frame is good iff the final residue is 8'h00. HEADER is excluded.
- Command codes: 8'hd1 single (COUNT implied 1), 8'hd2 burst, 8'he1 disable, 8'he2 enable. Enable/disable frames are CMD then CRC.
- The CRC register updates combinationally per byte and is registered on i_rx_byte_valid. No serial LFSR latency. All outputs are registered one cycle after the causing i_rx_byte_valid.
- HEADER state:
  - Clear crc and counters.
  - On valid byte == HEADER_BYTE go to CMD.
  - Other bytes are ignored silently.
- CMD state:
  - Pulse o_cmd_valid with o_cmd.
  - Known command: go to LEN (d2), PAYLOAD (d1, o_burst_cnt = 1) or CRC (e1/e2).
  - Unknown command: o_msg_done + o_msg_err, code 1, go to HEADER.
- LEN state:
  - COUNT == 0 or COUNT > MAX_BURST: abort with code 2.
  - Otherwise latch o_burst_cnt and go to PAYLOAD.
- PAYLOAD state:
  - Byte index counts 0..PAYLOAD_BYTES-1; each byte is written to lane [8*idx +: 8].
  - On the last byte, pulse o_payload_valid, reset idx and decrement the remaining count.
  - When remaining reaches 0, go to CRC.
  - o_payload holds its value between items and is not cleared.
- CRC state:
  - On a valid byte, pulse o_msg_done and go to HEADER.
  - Residue != 0: o_msg_err = 1, code 3.
  - Good e1 frame: o_pipeline_en <= 0 and o_core_rst_n low for one cycle.
  - Good e2 frame: o_pipeline_en <= 1.
  - A bad CRC leaves o_pipeline_en unchanged.
  - Payload items already pulsed are not retracted; consumers use o_msg_err.
- Timeout:
  - Applies when TIMEOUT_CYCLES > 0, in every state except HEADER.
  - The timer increments each cycle without a valid byte and clears on a valid byte.
  - When timer reaches TIMEOUT_CYCLES, abort with code 4.
- i_rx_err:
  - Has priority over everything in the same cycle, including a coincident valid byte.
  - In any state: abort with code 5, o_core_rst_n low for one cycle, go to HEADER. o_pipeline_en is unchanged.
- Abort means: one-cycle o_msg_done = o_msg_err = 1, set o_err_code, clear crc, idx and timer.
- A header byte arriving mid-frame is treated as data, with no resync.
- Asynchronous reset mid-frame returns everything to reset values immediately.

Test Plan:
- 5A E1 A9 -> o_cmd_valid with o_cmd = E1; o_msg_done, o_msg_err = 0; o_pipeline_en 1 -> 0; one-cycle o_core_rst_n low. Then 5A E2 + model CRC -> o_pipeline_en = 1.
- Single frame 5A D1 01 02 03 04 05 06 + model CRC -> one o_payload_valid with o_payload = 48'h060504030201; o_burst_cnt = 1; good o_msg_done.
- Burst 5A D2 03 + 18 bytes + CRC -> exactly 3 o_payload_valid pulses in order; good done. Repeat with the CRC byte XOR 01 -> o_msg_err = 1, code 3.
- 5A 77 -> err code 1. 5A D2 00 -> code 2. With MAX_BURST = 4, 5A D2 05 -> code 2. After each, a following good frame is parsed normally.
- TIMEOUT_CYCLES = 100: stall 100 cycles after the 3rd payload byte -> code 4 at that cycle; stall 99 cycles -> no abort.
- i_rx_err coincident with the 4th payload byte -> code 5, o_core_rst_n pulse, no o_payload_valid. Reset asserted mid-burst -> all outputs return to reset values.
